// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, HI/LO, single-cycle multiplier, iterative restoring divider.
// Optional ES_DIV_EARLY_EXIT_EN: trivial divides (x/0, |dividend|<|divisor|) skip the iterations.

module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  logic [31:0] w_add, w_sub, w_slt, w_sltu, w_sll, w_srl, w_sra, w_lui;

  assign w_add  = alu_src1 + alu_src2;
  assign w_sub  = alu_src1 - alu_src2;
  assign w_slt  = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
  assign w_sltu = {31'b0, alu_src1 < alu_src2};
  assign w_sll  = alu_src2 << alu_src1[4:0];
  assign w_srl  = alu_src2 >> alu_src1[4:0];
  assign w_sra  = $signed(alu_src2) >>> alu_src1[4:0];
  assign w_lui  = {alu_src2[15:0], 16'b0};

  assign alu_result = ({32{alu_op[0]}}  & w_add)
                    | ({32{alu_op[1]}}  & w_sub)
                    | ({32{alu_op[2]}}  & w_slt)
                    | ({32{alu_op[3]}}  & w_sltu)
                    | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                    | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                    | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                    | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                    | ({32{alu_op[8]}}  & w_sll)
                    | ({32{alu_op[9]}}  & w_srl)
                    | ({32{alu_op[10]}} & w_sra)
                    | ({32{alu_op[11]}} & w_lui);
endmodule

module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 146,
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int DIV_STEPS       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [5:0]                 es_stall_bus,
  output logic [32:0]                es_forward_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);
  localparam int CNT_W = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  logic                       r_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] r_ds_bus;
  logic [31:0]                r_hi, r_lo;
  div_state_t                 r_div_state, w_div_next;
  logic [CNT_W-1:0]           r_div_cnt;
  logic [31:0]                r_rem, r_quo, r_dvs;
  logic                       r_q_neg, r_r_neg;

  logic        w_hl_from_rs, w_load_op, w_src1_is_sa, w_src1_is_pc, w_src1_is_hi, w_src1_is_lo;
  logic        w_src2_is_imm, w_src2_is_uimm, w_src2_is_8, w_gr_we, w_hi_we, w_lo_we, w_mem_we;
  logic [11:0] w_alu_op;
  logic [1:0]  w_mul_op, w_div_op;
  logic [4:0]  w_dest;
  logic [15:0] w_imm;
  logic [31:0] w_rs, w_rt, w_pc, w_src1, w_src2, w_alu_result;
  logic        w_is_div, w_ready_go, w_fire, w_we, w_early;
  logic        w_dvd_neg, w_dvs_neg, w_ge;
  logic [31:0] w_dvd_abs, w_dvs_abs, w_quo_fix, w_rem_fix;
  logic [32:0] w_shift, w_sub;
  logic [63:0] w_m1, w_m2, w_prod;

  assign {w_hl_from_rs, w_alu_op, w_mul_op, w_div_op, w_load_op, w_src1_is_sa, w_src1_is_pc,
          w_src1_is_hi, w_src1_is_lo, w_src2_is_imm, w_src2_is_uimm, w_src2_is_8, w_gr_we,
          w_hi_we, w_lo_we, w_mem_we, w_dest, w_imm, w_rs, w_rt, w_pc} = r_ds_bus;

  assign w_is_div   = |w_div_op;
  assign w_ready_go = !w_is_div || (r_div_state == DIV_DONE);
  assign es_allowin = !r_es_valid || (w_ready_go && ms_allowin);
  assign w_fire     = r_es_valid && w_ready_go && ms_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_es_valid <= 1'b0;
      r_ds_bus   <= '0;
    end else begin
      if (es_allowin) r_es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) r_ds_bus <= ds_to_es_bus;
    end
  end

  assign w_src1 = w_src1_is_sa ? {27'b0, w_imm[10:6]} :
                  w_src1_is_pc ? w_pc :
                  w_src1_is_hi ? r_hi :
                  w_src1_is_lo ? r_lo : w_rs;
  assign w_src2 = w_src2_is_imm  ? {{16{w_imm[15]}}, w_imm} :
                  w_src2_is_uimm ? {16'b0, w_imm} :
                  w_src2_is_8    ? 32'd8 : w_rt;

  alu u_alu (
    .alu_op    (w_alu_op),
    .alu_src1  (w_src1),
    .alu_src2  (w_src2),
    .alu_result(w_alu_result)
  );

  // 33x33 product formed as a 64-bit multiply of sign/zero-extended operands (low 64 bits exact)
  assign w_m1   = {{32{w_mul_op[0] & w_rs[31]}}, w_rs};
  assign w_m2   = {{32{w_mul_op[0] & w_rt[31]}}, w_rt};
  assign w_prod = w_m1 * w_m2;

  assign w_dvd_neg = w_div_op[0] & w_rs[31];
  assign w_dvs_neg = w_div_op[0] & w_rt[31];
  assign w_dvd_abs = w_dvd_neg ? -w_rs : w_rs;
  assign w_dvs_abs = w_dvs_neg ? -w_rt : w_rt;

`ifdef ES_DIV_EARLY_EXIT_EN
  assign w_early = (w_dvs_abs == 32'd0) || (w_dvd_abs < w_dvs_abs);
`else
  assign w_early = 1'b0;
`endif

  assign w_shift   = {r_rem, r_quo[31]};
  assign w_sub     = w_shift - {1'b0, r_dvs};
  assign w_ge      = !w_sub[32];
  assign w_quo_fix = r_q_neg ? -r_quo : r_quo;
  assign w_rem_fix = r_r_neg ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (reset) r_div_state <= DIV_IDLE;
    else       r_div_state <= w_div_next;
  end

  always_comb begin
    w_div_next = r_div_state;
    case (r_div_state)
      DIV_IDLE: if (r_es_valid && w_is_div) w_div_next = w_early ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (r_div_cnt == CNT_W'(DIV_STEPS - 1)) w_div_next = DIV_DONE;
      DIV_DONE: if (w_fire) w_div_next = DIV_IDLE;
      default:  w_div_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
    end else if (r_div_state == DIV_IDLE && r_es_valid && w_is_div) begin
      r_div_cnt <= '0;
      r_rem     <= w_early ? w_dvd_abs : 32'd0;
      r_quo     <= w_early ? 32'd0 : w_dvd_abs;
      r_dvs     <= w_dvs_abs;
      r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
      r_r_neg   <= w_dvd_neg;
    end else if (r_div_state == DIV_BUSY) begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
      r_rem     <= w_ge ? w_sub[31:0] : w_shift[31:0];
      r_quo     <= {r_quo[30:0], w_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fire) begin
      if (w_is_div) begin
        r_lo <= w_quo_fix;
        r_hi <= w_rem_fix;
      end else if (|w_mul_op) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end else if (w_hl_from_rs) begin
        if (w_hi_we) r_hi <= w_rs;
        if (w_lo_we) r_lo <= w_rs;
      end
    end
  end

  assign w_we            = r_es_valid && w_gr_we;
  assign es_to_ms_valid  = r_es_valid && w_ready_go;
  assign es_to_ms_bus    = {w_load_op, w_gr_we, w_dest, w_alu_result, w_pc};
  assign es_stall_bus    = {w_we, w_dest};
  assign es_forward_bus  = {w_we && !w_load_op && w_ready_go, w_alu_result};
  assign data_sram_en    = 1'b1;
  assign data_sram_wen   = (r_es_valid && w_mem_we && ms_allowin) ? 4'hf : 4'h0;
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = w_rt;
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed cases plus randomized instruction stream
// checked against an arithmetic model of ALU, HI/LO, multiply and divide.

module tb_exe_stage;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ms_allowin = 1'b1;
  logic         ds_to_es_valid = 1'b0;
  logic [145:0] ds_to_es_bus = '0;
  logic         es_allowin, es_to_ms_valid, data_sram_en;
  logic [70:0]  es_to_ms_bus;
  logic [5:0]   es_stall_bus;
  logic [32:0]  es_forward_bus;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  exe_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .es_stall_bus(es_stall_bus), .es_forward_bus(es_forward_bus),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic hl; int aop; logic [1:0] mul, div;
    logic ld, sa, ispc, ishi, islo, imms, immu, is8, gr, hiwe, lowe, mw;
    logic [4:0] dest; logic [15:0] imm; logic [31:0] rs, rt, pc;
  } ins_t;

  typedef struct packed {
    logic [70:0] bus; logic mw; logic [31:0] addr; logic [31:0] wdata; logic fwd; logic [5:0] stall;
  } exp_t;

  exp_t        q_exp[$];
  int          checks = 0, errors = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic        rand_ms = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a & b;
      5: return ~(a | b);
      6: return a | b;
      7: return a ^ b;
      8: return b << a[4:0];
      9: return b >> a[4:0];
      10: return $signed(b) >>> a[4:0];
      11: return {b[15:0], 16'h0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic div_model(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    if (b == 0) begin
      r = a;
`ifdef ES_DIV_EARLY_EXIT_EN
      q = 32'd0;
`else
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
`endif
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  function automatic logic [145:0] pack(input ins_t i);
    logic [11:0] a;
    a = (i.aop >= 0) ? (12'b1 << i.aop) : 12'b0;
    return {i.hl, a, i.mul, i.div, i.ld, i.sa, i.ispc, i.ishi, i.islo, i.imms, i.immu, i.is8,
            i.gr, i.hiwe, i.lowe, i.mw, i.dest, i.imm, i.rs, i.rt, i.pc};
  endfunction

  function automatic ins_t blank();
    ins_t i;
    i = '{hl:0, aop:-1, mul:0, div:0, ld:0, sa:0, ispc:0, ishi:0, islo:0, imms:0, immu:0, is8:0,
          gr:0, hiwe:0, lowe:0, mw:0, dest:5'($urandom), imm:16'($urandom), rs:$urandom,
          rt:$urandom, pc:{$urandom_range(0, 32'h3FFF_FFFF), 2'b00}};
    return i;
  endfunction

  function automatic ins_t mk_alu(input int op, input logic [31:0] rs, input logic [31:0] rt);
    ins_t i = blank();
    i.aop = op; i.rs = rs; i.rt = rt; i.gr = 1;
    return i;
  endfunction

  function automatic ins_t mk_mul(input logic s, input logic [31:0] rs, input logic [31:0] rt);
    ins_t i = blank();
    i.mul = s ? 2'b01 : 2'b10; i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic ins_t mk_div(input logic s, input logic [31:0] rs, input logic [31:0] rt);
    ins_t i = blank();
    i.div = s ? 2'b01 : 2'b10; i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic ins_t mk_mf(input logic hi);
    ins_t i = blank();
    i.aop = 6; i.ishi = hi; i.islo = !hi; i.rt = 0; i.gr = 1;
    return i;
  endfunction

  task automatic send(input ins_t in);
    logic [31:0] s1, s2, res, q, r;
    logic [63:0] p;
    exp_t e;
    int n;
    s1 = in.sa ? {27'b0, in.imm[10:6]} : in.ispc ? in.pc : in.ishi ? m_hi : in.islo ? m_lo : in.rs;
    s2 = in.imms ? {{16{in.imm[15]}}, in.imm} : in.immu ? {16'b0, in.imm} : in.is8 ? 32'd8 : in.rt;
    res = ref_alu(in.aop, s1, s2);
    if (in.div != 0) begin
      div_model(in.div[0], in.rs, in.rt, q, r);
      m_lo = q; m_hi = r;
    end else if (in.mul != 0) begin
      if (in.mul[0]) p = 64'(longint'($signed(in.rs)) * longint'($signed(in.rt)));
      else           p = {32'b0, in.rs} * {32'b0, in.rt};
      m_hi = p[63:32]; m_lo = p[31:0];
    end else if (in.hl) begin
      if (in.hiwe) m_hi = in.rs;
      if (in.lowe) m_lo = in.rs;
    end
    e.bus = {in.ld, in.gr, in.dest, res, in.pc};
    e.mw = in.mw; e.addr = res; e.wdata = in.rt;
    e.fwd = in.gr && !in.ld; e.stall = {in.gr, in.dest};
    q_exp.push_back(e);
    ds_to_es_bus = pack(in);
    ds_to_es_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (es_allowin) break;
      n++;
      if (n > 200) begin chk("accept_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic wait_fire(output int lat, output int stalls);
    int c0 = cyc;
    lat = -1; stalls = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (es_to_ms_valid && ms_allowin) begin lat = cyc - c0; break; end
      if (!es_allowin) stalls++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q_exp.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk("drain_queue_empty", q_exp.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic ins_t gen();
    ins_t i;
    int k = $urandom_range(0, 10);
    logic [31:0] a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
    logic [31:0] b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
    case (k)
      0, 1, 2: begin
        i = mk_alu($urandom_range(0, 11), a, b);
        case ($urandom_range(0, 2))
          0: i.imms = 1;
          1: i.immu = 1;
          default: ;
        endcase
      end
      3: begin i = mk_alu($urandom_range(8, 10), a, b); i.sa = 1; end
      4: begin i = mk_alu(0, a, b); i.ispc = 1; i.is8 = 1; end
      5: i = mk_mul($urandom_range(0, 1), a, b);
      6: begin
        i = mk_div($urandom_range(0, 1), a, b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) i.rt = 32'd3;
      end
      7: begin
        i = blank(); i.hl = 1; i.rs = a;
        if ($urandom_range(0, 1) != 0) i.hiwe = 1; else i.lowe = 1;
      end
      8: i = mk_mf($urandom_range(0, 1));
      default: begin
        i = mk_alu(0, a, b); i.imms = 1;
        if ($urandom_range(0, 1) != 0) i.ld = 1; else begin i.mw = 1; i.gr = 0; end
      end
    endcase
    return i;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (es_to_ms_valid && ms_allowin) begin
        if (q_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fire actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = q_exp.pop_front();
          chk("es_to_ms_bus", es_to_ms_bus, e.bus);
          chk("sram_wen_fire", data_sram_wen, e.mw ? 4'hf : 4'h0);
          if (e.mw) begin
            chk("sram_addr", data_sram_addr, e.addr);
            chk("sram_wdata", data_sram_wdata, e.wdata);
          end
          chk("forward_valid", es_forward_bus[32], e.fwd);
          if (e.fwd) chk("forward_data", es_forward_bus[31:0], e.bus[63:32]);
          chk("stall_bus", es_stall_bus, e.stall);
        end
      end else begin
        chk("sram_wen_no_fire", data_sram_wen, 4'h0);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ms) ms_allowin = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    ins_t i;
    int lat, st, wcnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_es_to_ms_valid", es_to_ms_valid, 0);
    chk("reset_es_allowin", es_allowin, 1);
    chk("reset_forward_valid", es_forward_bus[32], 0);
    chk("reset_es_we", es_stall_bus[5], 0);
    chk("reset_sram_wen", data_sram_wen, 0);
    chk("sram_en", data_sram_en, 1);
    @(posedge clk); #1;
    send(mk_mf(1));
    send(mk_mf(0));

    // addiu 5 + 0xFFFF
    i = mk_alu(0, 32'd5, 32'd0); i.imms = 1; i.imm = 16'hFFFF; i.dest = 5'd9;
    send(i);
    @(negedge clk);
    chk("addiu_valid", es_to_ms_valid, 1);
    chk("addiu_result", es_to_ms_bus[63:32], 32'd4);
    chk("addiu_fwd_valid", es_forward_bus[32], 1);
    chk("addiu_stall_bus", es_stall_bus, {1'b1, 5'd9});
    @(posedge clk); #1;

    send(mk_mul(1, 32'hFFFF_FFFE, 32'd3)); send(mk_mf(1)); send(mk_mf(0));
    send(mk_mul(0, 32'hFFFF_FFFE, 32'd3)); send(mk_mf(1)); send(mk_mf(0));
    drain();

    send(mk_div(1, -32'sd7, 32'd2));
    wait_fire(lat, st);
    chk("div_fire_cycle", lat, 33);
    chk("div_stall_cycles", st, 33);
    send(mk_mf(0)); send(mk_mf(1));
    send(mk_div(0, 32'd100, 32'd7)); send(mk_mf(0)); send(mk_mf(1));
    send(mk_div(0, 32'd5, 32'd0)); send(mk_mf(0)); send(mk_mf(1));
    send(mk_div(1, -32'sd5, 32'd0)); send(mk_mf(0)); send(mk_mf(1));
    drain();

    // store held by memory stage for 3 cycles
    ms_allowin = 1'b0;
    i = mk_alu(0, 32'h1000, 32'hCAFE_F00D); i.imms = 1; i.imm = 16'h0010; i.mw = 1; i.gr = 0;
    send(i);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 ms_allowin = 1'b1;
    wcnt = 0;
    repeat (4) begin @(negedge clk); if (data_sram_wen == 4'hf) wcnt++; end
    chk("sw_wen_pulses", wcnt, 1);
    @(posedge clk); #1;
    drain();

    // reset during divide cycle 10
    send(mk_div(0, 32'd1000, 32'd3));
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    q_exp.delete(); m_hi = 0; m_lo = 0;
    @(negedge clk);
    chk("rst_div_allowin", es_allowin, 1);
    chk("rst_div_valid", es_to_ms_valid, 0);
    chk("rst_div_es_we", es_stall_bus[5], 0);
    @(posedge clk); #1;
    send(mk_mf(1)); send(mk_mf(0));
    drain();
    send(mk_div(0, 32'd9, 32'd3));
    wait_fire(lat, st);
    chk("divu_after_reset_cycle", lat, 33);
    send(mk_mf(0)); send(mk_mf(1));
    drain();

    send(mk_div(0, 32'd3, 32'd10));
    wait_fire(lat, st);
`ifdef ES_DIV_EARLY_EXIT_EN
    chk("divu_small_cycle", lat, 1);
`else
    chk("divu_small_cycle", lat, 33);
`endif
    chk("divu_small_stalls", st, lat);
    send(mk_mf(0)); send(mk_mf(1));
    drain();

    rand_ms = 1'b1;
    for (int n = 0; n < 300; n++) send(gen());
    rand_ms = 1'b0;
    @(posedge clk); #1 ms_allowin = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
